// File: rtl/boundary_corner_ctrl.sv
// boundary_corner_ctrl
// Collects the four corner coordinates streamed during a frame. At the first
// blanking line it snapshots them, derives the bounding box, validates it and
// commits it as the draw window for the next frame. Outputs only move inside
// blanking, 7 cycles after the frame boundary.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   VGA_X, VGA_Y               raster position (VGA_Y drives frame detection)
//   corner_valid/id/x/y        corner sample stream, one sample per cycle
//   draw_start_x/y, draw_end_x/y  committed window
//   cfg_valid                  window came from a detected frame
//   cfg_update                 one-cycle pulse when new outputs first appear
//   stale_cnt                  consecutive invalid frames (saturates at 255)
//
// state   | meaning
// COLLECT | filling capture bank, waiting for frame boundary
// MINMAX  | 4 cycles scanning the work bank for min/max x and y
// CHECK   | validate corner coverage and box size
// COMMIT  | update outputs or stale count
module boundary_corner_ctrl #(
    parameter int p_h_active    = 640,
    parameter int p_v_active    = 480,
    parameter int p_min_size    = 16,
    parameter int p_max_size    = 480,
    parameter int p_stale_limit = 4,
    parameter int p_def_x0      = 100,
    parameter int p_def_y0      = 100,
    parameter int p_def_x1      = 156,
    parameter int p_def_y1      = 156
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] VGA_X,
    input  logic [10:0] VGA_Y,
    input  logic        corner_valid,
    input  logic [1:0]  corner_id,
    input  logic [10:0] corner_x,
    input  logic [10:0] corner_y,
    output logic [10:0] draw_start_x,
    output logic [10:0] draw_start_y,
    output logic [10:0] draw_end_x,
    output logic [10:0] draw_end_y,
    output logic        cfg_valid,
    output logic        cfg_update,
    output logic [7:0]  stale_cnt
);

    typedef enum logic [1:0] {COLLECT, MINMAX, CHECK, COMMIT} state_t;

    state_t      state, state_nxt;
    logic [10:0] prev_y;
    logic        boundary, sample_ok, take_snap;

    logic [10:0] cap_x [4];
    logic [10:0] cap_y [4];
    logic [3:0]  cap_seen;
    logic [10:0] work_x [4];
    logic [10:0] work_y [4];
    logic [3:0]  work_seen;

    logic [1:0]  idx;
    logic [10:0] min_x, max_x, min_y, max_y;
    logic [10:0] box_w, box_h;
    logic        frame_ok;
    logic [7:0]  stale_nxt;
    logic        revert;

    // Column position is not needed: range filtering is done on corner_x.
    logic unused_vga_x;
    assign unused_vga_x = ^VGA_X;

    assign boundary  = (VGA_Y == 11'(p_v_active)) && (prev_y != 11'(p_v_active));
    assign sample_ok = corner_valid && (corner_x < 11'(p_h_active))
                       && (corner_y < 11'(p_v_active));
    assign take_snap = (state == COLLECT) && boundary;

    assign box_w = max_x - min_x;
    assign box_h = max_y - min_y;

    // Saturated increment; revert only fires on a real increment so a
    // saturated counter never re-pulses.
    assign stale_nxt = (stale_cnt == 8'hFF) ? 8'hFF : stale_cnt + 8'd1;
    assign revert    = (stale_cnt != 8'hFF) && (stale_nxt == 8'(p_stale_limit));

    always_ff @(posedge clk) begin
        if (reset) state <= COLLECT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (boundary) state_nxt = MINMAX;
            MINMAX:  if (idx == 2'd3) state_nxt = CHECK;
            CHECK:   state_nxt = COMMIT;
            COMMIT:  state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Raster edge tracking is left running through reset so that a reset
    // released inside blanking does not fake a boundary.
    always_ff @(posedge clk) prev_y <= VGA_Y;

    // Capture bank. The clear at the boundary comes last so a sample landing
    // in that cycle goes to the snapshot only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cap_x[i] <= '0;
                cap_y[i] <= '0;
            end
            cap_seen <= '0;
        end else begin
            if (sample_ok) begin
                cap_x[corner_id]    <= corner_x;
                cap_y[corner_id]    <= corner_y;
                cap_seen[corner_id] <= 1'b1;
            end
            if (take_snap) cap_seen <= '0;
        end
    end

    // Work bank, min/max scan and validation.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                work_x[i] <= '0;
                work_y[i] <= '0;
            end
            work_seen <= '0;
            idx       <= '0;
            min_x     <= '1;
            min_y     <= '1;
            max_x     <= '0;
            max_y     <= '0;
            frame_ok  <= 1'b0;
        end else begin
            if (take_snap) begin
                for (int i = 0; i < 4; i++) begin
                    work_x[i] <= (sample_ok && corner_id == 2'(i)) ? corner_x : cap_x[i];
                    work_y[i] <= (sample_ok && corner_id == 2'(i)) ? corner_y : cap_y[i];
                end
                work_seen <= cap_seen | (sample_ok ? (4'b0001 << corner_id) : 4'b0000);
                idx       <= '0;
                min_x     <= '1;
                min_y     <= '1;
                max_x     <= '0;
                max_y     <= '0;
            end else if (state == MINMAX) begin
                idx <= idx + 2'd1;
                if (work_x[idx] < min_x) min_x <= work_x[idx];
                if (work_x[idx] > max_x) max_x <= work_x[idx];
                if (work_y[idx] < min_y) min_y <= work_y[idx];
                if (work_y[idx] > max_y) max_y <= work_y[idx];
            end else if (state == CHECK) begin
                frame_ok <= (&work_seen)
                            && (box_w >= 11'(p_min_size)) && (box_w <= 11'(p_max_size))
                            && (box_h >= 11'(p_min_size)) && (box_h <= 11'(p_max_size));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            draw_start_x <= 11'(p_def_x0);
            draw_start_y <= 11'(p_def_y0);
            draw_end_x   <= 11'(p_def_x1);
            draw_end_y   <= 11'(p_def_y1);
            cfg_valid    <= 1'b0;
            cfg_update   <= 1'b0;
            stale_cnt    <= '0;
        end else begin
            cfg_update <= 1'b0;
            if (state == COMMIT) begin
                if (frame_ok) begin
                    draw_start_x <= min_x;
                    draw_start_y <= min_y;
                    draw_end_x   <= max_x;
                    draw_end_y   <= max_y;
                    cfg_valid    <= 1'b1;
                    cfg_update   <= 1'b1;
                    stale_cnt    <= '0;
                end else begin
                    stale_cnt <= stale_nxt;
                    if (revert) begin
                        draw_start_x <= 11'(p_def_x0);
                        draw_start_y <= 11'(p_def_y0);
                        draw_end_x   <= 11'(p_def_x1);
                        draw_end_y   <= 11'(p_def_y1);
                        cfg_valid    <= 1'b0;
                        cfg_update   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_boundary_corner_ctrl.sv
// Self-checking bench for boundary_corner_ctrl: a frame-level reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_boundary_corner_ctrl;

    localparam int H = 640, V = 480, MIN_SZ = 16, MAX_SZ = 480, LIMIT = 4;
    localparam int DX0 = 100, DY0 = 100, DX1 = 156, DY1 = 156;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] vga_x = '0, vga_y = '0;
    logic        corner_valid = 1'b0;
    logic [1:0]  corner_id = '0;
    logic [10:0] corner_x = '0, corner_y = '0;
    logic [10:0] draw_start_x, draw_start_y, draw_end_x, draw_end_y;
    logic        cfg_valid, cfg_update;
    logic [7:0]  stale_cnt;

    boundary_corner_ctrl dut (
        .clk(clk), .reset(reset), .VGA_X(vga_x), .VGA_Y(vga_y),
        .corner_valid(corner_valid), .corner_id(corner_id),
        .corner_x(corner_x), .corner_y(corner_y),
        .draw_start_x(draw_start_x), .draw_start_y(draw_start_y),
        .draw_end_x(draw_end_x), .draw_end_y(draw_end_y),
        .cfg_valid(cfg_valid), .cfg_update(cfg_update), .stale_cnt(stale_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int upd_count = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: frame-level view of capture, snapshot and commit.
    int m_cap_x [4], m_cap_y [4];
    bit m_cap_seen [4];
    int m_snap_x [4], m_snap_y [4];
    bit m_snap_seen [4];
    int m_prev_y = 0;
    int m_cnt = 0;
    bit m_init = 0;
    int e_sx = DX0, e_sy = DY0, e_ex = DX1, e_ey = DY1;
    int e_valid = 0, e_upd = 0, e_stale = 0;

    task automatic model_commit();
        int mnx, mny, mxx, mxy, w, h;
        bit all_seen;
        mnx = 1 << 30; mny = 1 << 30; mxx = -1; mxy = -1;
        all_seen = 1;
        for (int i = 0; i < 4; i++) begin
            if (!m_snap_seen[i]) all_seen = 0;
            if (m_snap_x[i] < mnx) mnx = m_snap_x[i];
            if (m_snap_y[i] < mny) mny = m_snap_y[i];
            if (m_snap_x[i] > mxx) mxx = m_snap_x[i];
            if (m_snap_y[i] > mxy) mxy = m_snap_y[i];
        end
        w = mxx - mnx;
        h = mxy - mny;
        if (all_seen && w >= MIN_SZ && w <= MAX_SZ && h >= MIN_SZ && h <= MAX_SZ) begin
            e_sx = mnx; e_sy = mny; e_ex = mxx; e_ey = mxy;
            e_valid = 1; e_upd = 1; e_stale = 0;
        end else if (e_stale < 255) begin
            e_stale++;
            if (e_stale == LIMIT) begin
                e_sx = DX0; e_sy = DY0; e_ex = DX1; e_ey = DY1;
                e_valid = 0; e_upd = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        bit busy;
        if (m_init) begin
            chk("draw_start_x", int'(draw_start_x), e_sx);
            chk("draw_start_y", int'(draw_start_y), e_sy);
            chk("draw_end_x",   int'(draw_end_x),   e_ex);
            chk("draw_end_y",   int'(draw_end_y),   e_ey);
            chk("cfg_valid",    int'(cfg_valid),    e_valid);
            chk("cfg_update",   int'(cfg_update),   e_upd);
            chk("stale_cnt",    int'(stale_cnt),    e_stale);
            if (cfg_update) upd_count++;
        end
        // Predict the outputs after the coming posedge.
        e_upd = 0;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_cap_x[i] = 0; m_cap_y[i] = 0; m_cap_seen[i] = 0;
            end
            m_cnt = 0;
            e_sx = DX0; e_sy = DY0; e_ex = DX1; e_ey = DY1;
            e_valid = 0; e_stale = 0;
            m_init = 1;
        end else begin
            busy = (m_cnt > 0);
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) model_commit();
            end
            if (corner_valid && int'(corner_x) < H && int'(corner_y) < V) begin
                m_cap_x[corner_id] = int'(corner_x);
                m_cap_y[corner_id] = int'(corner_y);
                m_cap_seen[corner_id] = 1;
            end
            if (!busy && int'(vga_y) == V && m_prev_y != V) begin
                for (int i = 0; i < 4; i++) begin
                    m_snap_x[i] = m_cap_x[i];
                    m_snap_y[i] = m_cap_y[i];
                    m_snap_seen[i] = m_cap_seen[i];
                    m_cap_seen[i] = 0;
                end
                m_cnt = 6;
            end
        end
        m_prev_y = int'(vga_y);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input int x, input int y);
        corner_valid = 1'b1;
        corner_id = 2'(id);
        corner_x = 11'(x);
        corner_y = 11'(y);
        tick();
        corner_valid = 1'b0;
        tick();
    endtask

    task automatic send4(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input int x3, input int y3);
        send(0, x0, y0); send(1, x1, y1); send(2, x2, y2); send(3, x3, y3);
    endtask

    task automatic frame_end();
        vga_y = 11'(V - 1);
        tick();
        vga_y = 11'(V);
        tick();
        repeat (12) tick();
        vga_y = 11'd0;
        tick();
    endtask

    task automatic chk_window(input string tag, input int sx, input int sy,
                              input int ex, input int ey);
        chk({tag, "_sx"}, int'(draw_start_x), sx);
        chk({tag, "_sy"}, int'(draw_start_y), sy);
        chk({tag, "_ex"}, int'(draw_end_x), ex);
        chk({tag, "_ey"}, int'(draw_end_y), ey);
    endtask

    int base;

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_window("reset", 100, 100, 156, 156);
        chk("reset_cfg_valid", int'(cfg_valid), 0);
        chk("reset_stale", int'(stale_cnt), 0);
        chk("reset_pulses", upd_count, 0);

        // Valid frame
        base = upd_count;
        send4(200, 120, 300, 118, 198, 260, 305, 262);
        frame_end();
        chk_window("valid", 198, 118, 305, 262);
        chk("valid_cfg_valid", int'(cfg_valid), 1);
        chk("valid_pulses", upd_count - base, 1);

        // Missing corner 3 on five frames
        for (int f = 1; f <= 5; f++) begin
            base = upd_count;
            send(0, 200, 120); send(1, 300, 118); send(2, 198, 260);
            frame_end();
            chk("miss_stale", int'(stale_cnt), f);
            if (f < 4) begin
                chk_window("miss_hold", 198, 118, 305, 262);
                chk("miss_hold_pulses", upd_count - base, 0);
            end else if (f == 4) begin
                chk_window("miss_revert", 100, 100, 156, 156);
                chk("miss_revert_valid", int'(cfg_valid), 0);
                chk("miss_revert_pulses", upd_count - base, 1);
            end else begin
                chk("miss_late_pulses", upd_count - base, 0);
            end
        end

        // Width 10: too narrow
        send4(200, 100, 210, 100, 200, 200, 210, 200);
        frame_end();
        chk("narrow_stale", int'(stale_cnt), 6);

        // x = 700 dropped, id 0 unseen
        send4(700, 100, 300, 100, 200, 200, 300, 200);
        frame_end();
        chk("range_stale", int'(stale_cnt), 7);

        // Width exactly 16
        base = upd_count;
        send4(200, 100, 216, 100, 200, 200, 216, 200);
        frame_end();
        chk_window("w16", 200, 100, 216, 200);
        chk("w16_stale", int'(stale_cnt), 0);
        chk("w16_pulses", upd_count - base, 1);

        // Corner at t0, corner at t0+2, second boundary during MINMAX
        send(0, 200, 120); send(1, 300, 118); send(2, 198, 260);
        vga_y = 11'(V - 1);
        tick();
        vga_y = 11'(V);
        corner_valid = 1'b1; corner_id = 2'd3; corner_x = 11'd400; corner_y = 11'd300;
        tick();
        corner_valid = 1'b0;
        vga_y = 11'(V - 1);
        tick();
        vga_y = 11'(V);
        corner_valid = 1'b1; corner_id = 2'd0; corner_x = 11'd250; corner_y = 11'd150;
        tick();
        corner_valid = 1'b0;
        base = upd_count;
        repeat (12) tick();
        vga_y = 11'd0;
        tick();
        chk_window("t0_corner", 198, 118, 400, 300);
        chk("t0_pulses", upd_count - base, 1);

        send(1, 300, 140); send(2, 240, 260); send(3, 310, 270);
        frame_end();
        chk_window("carry_id0", 240, 140, 310, 270);

        // Reset at t0+3
        base = upd_count;
        send4(150, 150, 350, 150, 150, 350, 350, 350);
        vga_y = 11'(V - 1);
        tick();
        vga_y = 11'(V);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (12) tick();
        vga_y = 11'd0;
        tick();
        chk_window("abort", 100, 100, 156, 156);
        chk("abort_valid", int'(cfg_valid), 0);
        chk("abort_pulses", upd_count - base, 0);

        send4(150, 150, 350, 150, 150, 350, 350, 350);
        frame_end();
        chk_window("after_abort", 150, 150, 350, 350);
        chk("after_abort_valid", int'(cfg_valid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boundary_corner_ctrl.md
# boundary_corner_ctrl

Per-frame configuration controller for the boundary-select draw datapath. It collects four corner coordinates streamed from the corner detector during a frame. At the start of vertical blanking it snapshots them and computes the bounding box (draw start/end). It validates the box and commits it as the draw window for the next frame. Outputs change only inside blanking, so the rotation/ROM path sees a stable window across active video; on repeated bad frames the window falls back to defaults.

## Interface
- p_h_active, 640, active pixels per line; corner samples with x >= this are dropped
- p_v_active, 480, active lines; VGA_Y == p_v_active is the first blanking line; samples with y >= this are dropped
- p_min_size, 16, minimum accepted box width and height (pixels)
- p_max_size, 480, maximum accepted box width and height
- p_stale_limit, 4, consecutive invalid frames before reverting to defaults (1..255)
- p_def_x0 / p_def_y0 / p_def_x1 / p_def_y1, 100/100/156/156, default draw_start/draw_end
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- VGA_X  in  11  current pixel column (unsigned)
- VGA_Y  in  11  current line (unsigned)
- corner_valid  in  1  corner sample strobe, one sample per cycle
- corner_id  in  2  0=top-left, 1=top-right, 2=bottom-left, 3=bottom-right
- corner_x, corner_y  in  11 each  corner coordinate (unsigned)
- draw_start_x, draw_start_y  out  11 each  committed window start
- draw_end_x, draw_end_y  out  11 each  committed window end
- cfg_valid  out  1  window came from a valid detected frame
- cfg_update  out  1  one-cycle pulse in the first cycle new output values are visible
- stale_cnt  out  8  consecutive invalid frames, saturating at 255

## Operation
- Capture bank: 4 x (x,y) registers plus seen[3:0]. Every cycle with corner_valid and an in-range sample, write bank[corner_id] and set seen[corner_id]. The latest sample wins.
- Frame boundary at cycle t0: VGA_Y == p_v_active and registered previous VGA_Y != p_v_active.
- States: COLLECT (reset state), MINMAX, CHECK, COMMIT.
- COLLECT and boundary:
  - Copy the capture bank and seen into the work bank and go to MINMAX.
  - Clear capture seen in the same cycle.
  - A corner sample in cycle t0 belongs to the closing frame and is included in the snapshot.
- MINMAX: 4 cycles. A 2-bit index steps over the work bank, tracking min/max of x and y.
- CHECK: 1 cycle. The frame is valid iff:
  - all four work seen bits are set;
  - w = max_x - min_x and h = max_y - min_y (11-bit unsigned, non-negative by construction) both satisfy p_min_size <= value <= p_max_size.
- COMMIT: 1 cycle, then back to COLLECT.
  - Valid frame: outputs <= (min_x, min_y, max_x, max_y), cfg_valid <= 1, stale_cnt <= 0, cfg_update pulses on every valid commit, including when values are unchanged.
  - Invalid frame: stale_cnt increments, saturating at 255. Outputs hold, with no pulse.
  - Revert: when the incremented stale_cnt equals p_stale_limit, outputs <= defaults, cfg_valid <= 0 and cfg_update pulses. Later invalid frames do not pulse.
- Corner samples arriving during MINMAX/CHECK/COMMIT go to the capture bank (next frame) and are unaffected by processing.
- A boundary while not in COLLECT is ignored.
- Reset mid-processing aborts to COLLECT and clears both banks. Outputs take reset values in the next cycle.

## Timing
- Reset values:
  - draw_start = (p_def_x0, p_def_y0), draw_end = (p_def_x1, p_def_y1)
  - cfg_valid = 0, cfg_update = 0, stale_cnt = 0
  - seen bits = 0, state = COLLECT
- t0: boundary detected and snapshot taken.
- t0+1..t0+4: MINMAX.
- t0+5: CHECK.
- t0+6: COMMIT.
- t0+7: new outputs visible; cfg_update high for this cycle only.
- Fixed 7-cycle boundary-to-output latency, well inside vertical blanking.
- Outputs are registered; there is no combinational path from inputs to outputs.
- VGA_Y held at p_v_active for many cycles produces exactly one boundary.

## Test plan
- Reset values: after reset -> outputs (100,100,156,156), cfg_valid=0, stale_cnt=0, no cfg_update.
- Valid frame: corners (200,120), (300,118), (198,260), (305,262), then VGA_Y steps 479->480 -> at t0+7 draw_start=(198,118), draw_end=(305,262), cfg_valid=1, cfg_update for exactly 1 cycle.
- Missing corner and revert (p_stale_limit=4): only ids 0,1,2 sent per frame -> stale_cnt 1,2,3 with outputs held and no pulse. 4th frame -> defaults, cfg_valid=0, one pulse. 5th frame -> stale_cnt=5, no pulse.
- Size and range limits:
  - box width 10 (< p_min_size) -> invalid, stale_cnt increments;
  - corner_x=700 dropped, so that id is unseen -> invalid;
  - width exactly 16 -> valid.
- Simultaneous events:
  - corner id 3 (400,300) at t0 -> included in the snapshot;
  - corner id 0 at t0+2 -> absent from this commit but present in the next frame's capture;
  - second boundary pulse during MINMAX -> ignored.
- Reset at t0+3 -> state COLLECT, outputs defaults, no cfg_update. The next full frame commits normally.
